// File: rtl/noc_flit_receiver.sv
// Receive endpoint for the 3x3 mesh NoC: reassembles head/body/tail flits addressed
// to this node into a buffered payload-word stream, dropping and counting bad traffic.
module noc_flit_receiver #(
    parameter int PL      = 32,
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 8,
    parameter int SKID    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [0:PL-1] flitIn,
    output logic          avail,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PL-3:0] out_data,
    output logic [3:0]    out_src,
    output logic          out_first,
    output logic          out_last,
    output logic [7:0]    drop_count,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = PL + 4;
    localparam logic [3:0] MY_ID = 4'(NODE_ID);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] SKID_W = (AW+1)'(SKID);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    state_t        state;
    logic [7:0]    rem;
    logic [3:0]    src_q;
    logic          first_q;

    logic [1:0]    ftype;
    logic          is_head, is_data, is_tail;
    logic [3:0]    h_src, h_dst;
    logic [7:0]    h_len;
    logic [PL-3:0] payload;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, next_count;
    logic          push, push_ok, pop, drop_inc, rec_last;
    logic [EW-1:0] push_word;

    assign ftype   = flitIn[0:1];
    assign is_head = (ftype == 2'b01);
    assign is_data = ftype[1];
    assign is_tail = (ftype == 2'b11);
    assign h_src   = flitIn[2:5];
    assign h_dst   = flitIn[6:9];
    assign h_len   = flitIn[10:17];
    assign payload = flitIn[2:PL-1];

    always_comb begin
        rec_last  = (rem == 8'd1) || is_tail;
        push      = (state == RECV) && is_data;
        push_word = {first_q, rec_last, src_q, payload};
        drop_inc  = 1'b0;
        case (state)
            IDLE:    drop_inc = is_data || (is_head && (h_dst != MY_ID || h_len == 8'd0));
            RECV:    drop_inc = is_head || (is_data && rec_last &&
                                ((is_tail && rem > 8'd1) || (!is_tail && rem == 8'd1)));
            DISCARD: drop_inc = is_head;
            default: drop_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rem     <= '0;
            src_q   <= '0;
            first_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (is_head && h_len != 8'd0) begin
                    rem <= h_len;
                    if (h_dst == MY_ID) begin
                        src_q   <= h_src;
                        first_q <= 1'b1;
                        state   <= RECV;
                    end else begin
                        state <= DISCARD;
                    end
                end
                RECV: if (is_data) begin
                    first_q <= 1'b0;
                    rem     <= rem - 8'd1;
                    if (rec_last) state <= IDLE;
                end
                DISCARD: if (is_data) begin
                    rem <= rem - 8'd1;
                    if (rec_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A push into a full FIFO still succeeds when the head is popped in the same cycle.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && ((count < FULL) || pop);
    assign {out_first, out_last, out_src, out_data} = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        next_count = count;
        if (push_ok && !pop)
            next_count = count + 1'b1;
        else if (!push_ok && pop)
            next_count = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            avail      <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= next_count;
            avail <= (FULL - next_count) > SKID_W;
            if (push && !push_ok) overflow <= 1'b1;
            if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_noc_flit_receiver.sv
// Directed bench for noc_flit_receiver: stimulus pushes expected words into a queue,
// an independent monitor pops and compares on every output handshake.
module tb_noc_flit_receiver;

    localparam int PL    = 32;
    localparam int DEPTH = 8;
    localparam int SKID  = 2;
    localparam int NID   = 5;

    typedef logic [PL+3:0] word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [0:PL-1] flitIn = '0;
    logic          out_ready = 1'b0;
    logic          avail, out_valid, out_first, out_last, overflow;
    logic [PL-3:0] out_data;
    logic [3:0]    out_src;
    logic [7:0]    drop_count;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    noc_flit_receiver #(.PL(PL), .NODE_ID(NID), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk(clk), .rst_n(rst_n), .flitIn(flitIn), .avail(avail),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_first(out_first), .out_last(out_last),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [0:PL-1] mk_head(logic [3:0] s, logic [3:0] d, logic [7:0] l);
        logic [0:PL-1] f = '0;
        f[0:1] = 2'b01; f[2:5] = s; f[6:9] = d; f[10:17] = l;
        return f;
    endfunction

    function automatic logic [0:PL-1] mk_data(logic tail, logic [PL-3:0] p);
        logic [0:PL-1] f = '0;
        f[0:1] = tail ? 2'b11 : 2'b10;
        f[2:PL-1] = p;
        return f;
    endfunction

    function automatic word_t mk_word(logic first, logic last, logic [3:0] src, logic [PL-3:0] d);
        return {first, last, src, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drives one flit for one sampling edge; returns at posedge+1.
    task automatic send(input logic [0:PL-1] f);
        flitIn = f;
        @(posedge clk);
        #1;
        flitIn = '0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        word_t act, req;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                act = {out_first, out_last, out_src, out_data};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", act);
                end else begin
                    req = exp_q.pop_front();
                    if (act !== req) begin
                        errors++;
                        $display("FAIL out_word actual=%0h required=%0h", act, req);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not terminate");
    end

    initial begin : stim
        logic exp_avail;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_avail", 64'(avail), 0);
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_fields", 64'({out_first, out_last, out_src, out_data}), 0);
        chk("rst_drop", 64'(drop_count), 0);
        chk("rst_ovf", 64'(overflow), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("avail_after_rst", 64'(avail), 1);

        // Basic 3-word packet
        out_ready = 1'b1;
        send(mk_head(4'd4, 4'(NID), 8'd3));
        exp_q.push_back(mk_word(1, 0, 4'd4, 30'h0AAA_0001));
        send(mk_data(0, 30'h0AAA_0001));
        exp_q.push_back(mk_word(0, 0, 4'd4, 30'h0BBB_0002));
        send(mk_data(0, 30'h0BBB_0002));
        exp_q.push_back(mk_word(0, 1, 4'd4, 30'h0CCC_0003));
        send(mk_data(1, 30'h0CCC_0003));
        drain("t1_drain");
        chk("t1_drop", 64'(drop_count), 0);

        // Misaddressed packet discarded, then a 1-flit packet
        send(mk_head(4'd2, 4'd7, 8'd2));
        send(mk_data(0, 30'h1111));
        send(mk_data(1, 30'h2222));
        repeat (2) @(posedge clk);
        #1;
        chk("t2_drop", 64'(drop_count), 1);
        chk("t2_no_valid", 64'(out_valid), 0);
        exp_q.push_back(mk_word(1, 1, 4'd3, 30'h0DDD_0004));
        send(mk_head(4'd3, 4'(NID), 8'd1));
        send(mk_data(1, 30'h0DDD_0004));
        drain("t2_drain");
        chk("t2_drop_after", 64'(drop_count), 1);

        // Early tail, then zero-length head, then a good packet
        exp_q.push_back(mk_word(1, 1, 4'd6, 30'h0EEE_0005));
        send(mk_head(4'd6, 4'(NID), 8'd3));
        send(mk_data(1, 30'h0EEE_0005));
        drain("t4_drain");
        chk("t4_drop_tail", 64'(drop_count), 2);
        send(mk_head(4'd6, 4'(NID), 8'd0));
        repeat (2) @(posedge clk);
        #1;
        chk("t4_drop_len0", 64'(drop_count), 3);
        chk("t4_no_valid", 64'(out_valid), 0);
        exp_q.push_back(mk_word(1, 1, 4'd7, 30'h0FFF_0006));
        send(mk_head(4'd7, 4'(NID), 8'd1));
        send(mk_data(1, 30'h0FFF_0006));
        drain("t4_drain2");

        // Backpressure: 10 words into an 8-deep FIFO
        do_reset();
        out_ready = 1'b0;
        send(mk_head(4'd1, 4'(NID), 8'd10));
        for (int k = 1; k <= 10; k++) begin
            if (k <= DEPTH) exp_q.push_back(mk_word(k == 1, 0, 4'd1, 30'(32'h100 + k)));
            send(mk_data(k == 10, 30'(32'h100 + k)));
            exp_avail = (DEPTH - ((k > DEPTH) ? DEPTH : k)) > SKID;
            chk($sformatf("t3_avail_%0d", k), 64'(avail), 64'(exp_avail));
        end
        chk("t3_ovf", 64'(overflow), 1);
        chk("t3_hold_data", 64'(out_data), 64'h101);
        chk("t3_hold_first", 64'(out_first), 1);
        out_ready = 1'b1;
        drain("t3_drain");
        chk("t3_avail_back", 64'(avail), 1);
        chk("t3_drop", 64'(drop_count), 0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        out_ready = 1'b0;
        send(mk_head(4'd2, 4'(NID), 8'd20));
        for (int k = 1; k <= 20; k++) begin
            if (k == 9) out_ready = 1'b1;
            exp_q.push_back(mk_word(k == 1, k == 20, 4'd2, 30'(32'h200 + k)));
            send(mk_data(k == 20, 30'(32'h200 + k)));
            if (k >= 9) begin
                chk($sformatf("t5_avail_%0d", k), 64'(avail), 0);
                chk($sformatf("t5_ovf_%0d", k), 64'(overflow), 0);
            end
        end
        drain("t5_drain");
        chk("t5_drop", 64'(drop_count), 0);

        // Reset in the middle of a packet
        do_reset();
        out_ready = 1'b0;
        send(mk_head(4'd4, 4'(NID), 8'd4));
        send(mk_data(0, 30'h301));
        send(mk_data(0, 30'h302));
        chk("t6_pre_valid", 64'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 0);
        chk("t6_rst_fields", 64'({out_first, out_last, out_src, out_data}), 0);
        chk("t6_rst_avail", 64'(avail), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(mk_data(0, 30'h303));
        send(mk_data(1, 30'h304));
        repeat (3) @(posedge clk);
        #1;
        chk("t6_drop", 64'(drop_count), 2);
        chk("t6_no_valid", 64'(out_valid), 0);
        chk("t6_queue", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_flit_receiver.md
# noc_flit_receiver

Core-side receive endpoint for the 3x3 mesh NoC. It samples the flit stream that the local router drives into a node, reassembles head/body/tail flits addressed to this node into a payload-word stream with valid/ready handshake, and buffers words in a FIFO. It drives the node's availability signal back to the NoC so in-flight flits always fit, and it drops misaddressed or malformed packets with a counter.

## Interface
- PL, 32: flit width; bit 0 is MSB (`[0:PL-1]` indexing)
- NODE_ID, 0: this node's ID (row*3+col)
- DEPTH, 8: payload FIFO entries, power of 2, at least 4
- SKID, 2: free entries reserved for flits in flight after `avail` falls
- Clock/reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flitIn  in  PL  flit from local router port
- avail  out  1  node may accept flits (to NoC availability input)
- out_valid  out  1  payload word present
- out_ready  in  1  core accepts word
- out_data  out  PL-2  payload word
- out_src  out  4  source node of the word's packet
- out_first  out  1  first word of packet
- out_last  out  1  last word of packet
- drop_count  out  8  saturating count of dropped or malformed flits/packets
- overflow  out  1  sticky; a payload word was lost to a full FIFO

## Operation
- Flit type is `flitIn[0:1]`:
  - 00: idle, ignored in every state
  - 01: head
  - 10: body
  - 11: tail
- Head fields:
  - `[2:5]` src
  - `[6:9]` dst
  - `[10:17]` len, the number of payload flits, 1..255
  - rest reserved
- Body/tail field: `[2:PL-1]` payload.
- FSM states are IDLE, RECV and DISCARD. Registers: `rem` (8b), `src_q`, `first_q`.
- IDLE:
  - Head with dst==NODE_ID and len>0: latch src, rem=len, first_q=1, go to RECV.
  - Head with dst!=NODE_ID: drop_count+1, rem=len, go to DISCARD. If len==0, stay in IDLE instead.
  - Head with dst==NODE_ID and len==0: drop_count+1, stay in IDLE.
  - Stray body/tail: drop_count+1.
- RECV, on a body/tail flit:
  - Push {first_q, last, src_q, payload}. last = (rem==1) or type==tail.
  - Clear first_q; rem-1.
  - If last: go to IDLE.
  - If last and type mismatches (tail with rem>1, or body with rem==1): drop_count+1.
  - A head flit in RECV is ignored and drop_count+1; the state is unchanged.
- DISCARD:
  - Body/tail: rem-1; go to IDLE when rem==1 or type==tail.
  - Head: ignored, counted.
- FIFO:
  - A push is accepted if count<DEPTH or a pop occurs in the same cycle.
  - Otherwise the word is lost and overflow is set to 1. The FSM still advances exactly as if the push had been accepted.
- Pop when out_valid and out_ready.
- avail = registered (DEPTH − next_count) > SKID.
- drop_count saturates at 255. It and overflow clear only on reset.

## Timing
- Reset values:
  - avail=0, out_valid=0, out_data=0, out_src=0, out_first=0, out_last=0
  - drop_count=0, overflow=0
  - FSM=IDLE, FIFO empty
- avail rises on the first clock edge after rst_n deasserts.
- flitIn is sampled at the rising edge. An accepted word appears at the FIFO head with out_valid=1 from the next cycle: 1-cycle latency for an empty FIFO.
- out_* fields are stable while out_valid=1 and out_ready=0.
- Full FIFO with pop and push in the same cycle: both occur, count unchanged, no overflow.
- Empty FIFO: no bypass; a word pushed in cycle N is visible in cycle N+1.
- rst_n asserted mid-packet: immediately IDLE, FIFO flushed. The remainder of that packet is then treated as stray body/tail flits and counted.
- avail lags count by one cycle. SKID covers the 1-cycle avail lag plus 1 flit of router pipeline.

## Test plan
- Reset, then head(src=4, dst=NODE_ID, len=3) + body A + body B + tail C, out_ready=1 -> 3 words A,B,C with src=4; first only on A, last only on C; drop_count=0.
- Head with dst!=NODE_ID, len=2, followed by 2 flits -> no out_valid; drop_count=1; a following valid 1-flit packet is delivered normally.
- out_ready=0, stream a 10-flit packet with DEPTH=8, SKID=2 -> avail falls after the 6th word is pushed; 8 words are buffered and 2 lost; overflow=1. Releasing out_ready drains the 8 words in order.
- Tail arriving with rem=3 -> that word has out_last=1, FSM returns to IDLE, drop_count=1. A head with len=0 -> drop_count=2, no output.
- FIFO full with out_ready=1 and continuous flits -> one push and one pop per cycle, count stays 8, overflow stays 0.
- rst_n pulsed after 2 of 4 payload flits -> outputs return to reset values. The 2 remaining flits -> drop_count=2, no output.
